// File: rtl/rf_write_sched_if.sv
// Requester A/B write handshakes and the registered write port toward rf_32.
// The master side drives the requests and observes the grants and the rf strobe.
interface rf_write_sched_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        rf_write_enabled;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_write_enabled, rf_write_addr, rf_write_data
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_write_enabled, rf_write_addr, rf_write_data
    );
endinterface

// File: rtl/rf_write_sched.sv
// Write-port scheduler for rf_32: round-robin A/B arbitration plus a 32-entry init walk.
// Defining RF_SCHED_STATS_EN adds the saturating conflict_count output.
module rf_write_sched #(
    parameter logic [31:0] INIT_VALUE       = 32'h0000_0000,
    parameter bit          INIT_ON_RESET    = 1'b1,
    parameter bit          ZERO_REG_PROTECT = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic init_start,
    output logic init_busy,
    output logic init_done,
`ifdef RF_SCHED_STATS_EN
    output logic [15:0] conflict_count,
`endif
    rf_write_sched_if.slave bus
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {REQ_A, REQ_B} req_t;

    state_t      state_q, state_d;
    req_t        rr_last_q, rr_last_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        init_done_q, init_done_d;
    logic        grant_a, grant_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            rr_last_q   <= REQ_B;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        init_done_d = 1'b0;
        grant_a     = 1'b0;
        grant_b     = 1'b0;

        case (state_q)
            ST_INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = INIT_VALUE;
                if (cnt_q == 5'd31) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                if (init_start) begin
                    state_d = ST_INIT;
                end else begin
                    // On a tie the requester that did not win last time is served.
                    grant_a = bus.a_valid && (!bus.b_valid || rr_last_q == REQ_B);
                    grant_b = bus.b_valid && !grant_a;
                    if (grant_a) begin
                        waddr_d   = bus.a_addr;
                        wdata_d   = bus.a_data;
                        we_d      = !(ZERO_REG_PROTECT && bus.a_addr == 5'd0);
                        rr_last_d = REQ_A;
                    end else if (grant_b) begin
                        waddr_d   = bus.b_addr;
                        wdata_d   = bus.b_data;
                        we_d      = !(ZERO_REG_PROTECT && bus.b_addr == 5'd0);
                        rr_last_d = REQ_B;
                    end
                end
            end
        endcase
    end

    assign bus.a_ready          = grant_a;
    assign bus.b_ready          = grant_b;
    assign bus.rf_write_enabled = we_q;
    assign bus.rf_write_addr    = waddr_q;
    assign bus.rf_write_data    = wdata_q;
    assign init_busy            = (state_q == ST_INIT);
    assign init_done            = init_done_q;

`ifdef RF_SCHED_STATS_EN
    logic [15:0] conflict_q, conflict_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) conflict_q <= '0;
        else       conflict_q <= conflict_d;
    end

    always_comb begin
        conflict_d = conflict_q;
        if (state_q == ST_RUN) begin
            if (init_start)
                conflict_d = '0;
            else if (bus.a_valid && bus.b_valid && conflict_q != 16'hFFFF)
                conflict_d = conflict_q + 16'd1;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched: stimulus pushes hand-computed rf writes into a
// queue, a negedge monitor pops and compares each strobe; a tb-side array stands in for rf_32.
module tb_rf_write_sched;

    logic clock = 1'b0;
    logic reset;
    logic init_start;
    logic init_busy;
    logic init_done;
`ifdef RF_SCHED_STATS_EN
    logic [15:0] conflict_count;
`endif

    rf_write_sched_if bus ();

    rf_write_sched #(
        .INIT_VALUE      (32'h0000_0000),
        .INIT_ON_RESET   (1'b1),
        .ZERO_REG_PROTECT(1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .init_start    (init_start),
        .init_busy     (init_busy),
        .init_done     (init_done),
`ifdef RF_SCHED_STATS_EN
        .conflict_count(conflict_count),
`endif
        .bus           (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] rf_mem [32];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural stand-in for rf_32: captures on the strobe edge.
    always @(posedge clock)
        if (bus.rf_write_enabled === 1'b1)
            rf_mem[bus.rf_write_addr] <= bus.rf_write_data;

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.rf_write_enabled === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got addr %0d data %h expected none",
                         bus.rf_write_addr, bus.rf_write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("strobe_addr", {27'd0, bus.rf_write_addr}, {27'd0, e.addr});
                chk("strobe_data", bus.rf_write_data, e.data);
            end
        end
    end

    task automatic push_init();
        for (int i = 0; i < 32; i++) exp_q.push_back({i[4:0], 32'h0000_0000});
    endtask

    // Call from a negedge one posedge before the first walk strobe.
    task automatic wait_init(output int n);
        n = 40;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (init_done === 1'b1) begin
                n = i;
                break;
            end
            chk("init_busy", {31'd0, init_busy}, 32'd1);
            chk("a_ready_in_init", {31'd0, bus.a_ready}, 32'd0);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    int n;
    int grant_a_tbl [4] = '{1, 0, 1, 0};

    initial begin
        reset = 1'b1;
        init_start = 1'b0;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_we",        {31'd0, bus.rf_write_enabled}, 32'd0);
        chk("rst_addr",      {27'd0, bus.rf_write_addr}, 32'd0);
        chk("rst_data",      bus.rf_write_data, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_init_busy", {31'd0, init_busy}, 32'd1);

        // Init walk after reset, A waiting with a held request
        push_init();
        bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 32'h1234_5678;
        reset = 1'b0;
        wait_init(n);
        chk("init_len", n, 32);
        chk("done_last_addr", {27'd0, bus.rf_write_addr}, 32'd31);
        chk("a_ready_after_init", {31'd0, bus.a_ready}, 32'd1);
        chk("busy_after_init", {31'd0, init_busy}, 32'd0);
        exp_q.push_back({5'd9, 32'h1234_5678});
        cyc();
        bus.a_valid = 1'b0;
        @(negedge clock);
        chk("init_done_pulse", {31'd0, init_done}, 32'd0);
        cyc();
        for (int i = 0; i < 32; i++)
            chk($sformatf("rf_after_init_%0d", i), rf_mem[i], (i == 9) ? 32'h1234_5678 : 32'h0);

        // Single A write
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("a5_ready", {31'd0, bus.a_ready}, 32'd1);
        chk("a5_b_ready", {31'd0, bus.b_ready}, 32'd0);
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        cyc();
        bus.a_valid = 1'b0;
        cyc();
        cyc();
        chk("rf5", rf_mem[5], 32'hDEAD_BEEF);

        // B alone so that B is the last winner, then a 4-cycle tie
        bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h4444_4444;
        @(negedge clock);
        chk("b4_ready", {31'd0, bus.b_ready}, 32'd1);
        exp_q.push_back({5'd4, 32'h4444_4444});
        cyc();
        bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = 32'h1111_1111;
        bus.b_addr = 5'd3; bus.b_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("tie%0d_a_ready", i), {31'd0, bus.a_ready}, grant_a_tbl[i]);
            chk($sformatf("tie%0d_b_ready", i), {31'd0, bus.b_ready}, 1 - grant_a_tbl[i]);
            if (grant_a_tbl[i] == 1) exp_q.push_back({5'd2, 32'h1111_1111});
            else                     exp_q.push_back({5'd3, 32'h2222_2222});
            cyc();
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge clock);
`ifdef RF_SCHED_STATS_EN
        chk("conflict_count", {16'd0, conflict_count}, 32'd4);
`endif
        cyc();
        chk("rf2", rf_mem[2], 32'h1111_1111);
        chk("rf3", rf_mem[3], 32'h2222_2222);

        // Address-0 write accepted but not strobed; next tie goes to B
        bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("a0_ready", {31'd0, bus.a_ready}, 32'd1);
        cyc();
        bus.a_addr = 5'd1; bus.a_data = 32'h1111_0000;
        bus.b_valid = 1'b1; bus.b_addr = 5'd6; bus.b_data = 32'h6666_6666;
        @(negedge clock);
        chk("a0_no_strobe", {31'd0, bus.rf_write_enabled}, 32'd0);
        chk("tie_after_a0_b", {31'd0, bus.b_ready}, 32'd1);
        chk("tie_after_a0_a", {31'd0, bus.a_ready}, 32'd0);
        exp_q.push_back({5'd6, 32'h6666_6666});
        cyc();
        bus.b_valid = 1'b0;
        @(negedge clock);
        chk("loser_next", {31'd0, bus.a_ready}, 32'd1);
        exp_q.push_back({5'd1, 32'h1111_0000});
        cyc();
        bus.a_valid = 1'b0;
        cyc();
        cyc();
        chk("rf0_kept", rf_mem[0], 32'h0);
        chk("rf6", rf_mem[6], 32'h6666_6666);

        // init_start beats a pending A request
        bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h7777_7777;
        init_start = 1'b1;
        @(negedge clock);
        chk("init_start_a_ready", {31'd0, bus.a_ready}, 32'd0);
        push_init();
        cyc();
        init_start = 1'b0;
        @(negedge clock);
        chk("reinit_busy", {31'd0, init_busy}, 32'd1);
        wait_init(n);
        chk("reinit_len", n, 32);
        chk("a7_ready_after", {31'd0, bus.a_ready}, 32'd1);
        exp_q.push_back({5'd7, 32'h7777_7777});
        cyc();
        bus.a_valid = 1'b0;
        cyc();
        cyc();
        chk("rf7", rf_mem[7], 32'h7777_7777);
        chk("rf5_wiped", rf_mem[5], 32'h0);
`ifdef RF_SCHED_STATS_EN
        chk("conflict_cleared", {16'd0, conflict_count}, 32'd0);
`endif

        // Reset in the middle of the walk (cnt = 10)
        init_start = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back({i[4:0], 32'h0});
        cyc();
        init_start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("mid_addr9", {27'd0, bus.rf_write_addr}, 32'd9);
        #1 reset = 1'b1;
        #1;
        chk("async_we",   {31'd0, bus.rf_write_enabled}, 32'd0);
        chk("async_addr", {27'd0, bus.rf_write_addr}, 32'd0);
        chk("async_data", bus.rf_write_data, 32'd0);
        repeat (2) @(negedge clock);
        push_init();
        reset = 1'b0;
        wait_init(n);
        chk("restart_len", n, 32);

        repeat (3) @(negedge clock);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Write-port scheduler/initialiser in front of the 32x32 register file (rf_32).
- Shares the single rf write port between two writeback requesters, A (ALU) and B (load), using valid/ready handshakes and round-robin arbitration.
- Owns a sequencer that walks all 32 registers writing INIT_VALUE, so no register reads as X after reset or on demand.
- Drives rf_32 write_enabled/write_addr/write_data directly from registered outputs.

Parameters:
- INIT_VALUE, 32'h00000000, value written to every register during INIT.
- INIT_ON_RESET, 1, 1 = enter INIT when reset releases; 0 = enter RUN.
- ZERO_REG_PROTECT, 1, 1 = requester writes to address 0 are accepted but never strobed to the rf.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- init_start  in  1  pulse: request a full-file initialisation
- init_busy  out  1  high while state==INIT
- init_done  out  1  one-cycle pulse on the INIT->RUN transition
- a_valid  in  1  requester A has a write
- a_ready  out  1  A transfer accepted this cycle
- a_addr  in  5  A destination register
- a_data  in  32  A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  B transfer accepted this cycle
- b_addr  in  5  B destination register
- b_data  in  32  B write data
- rf_write_enabled  out  1  to rf_32 write_enabled
- rf_write_addr  out  5  to rf_32 write_addr
- rf_write_data  out  32  to rf_32 write_data

Behaviour:
- Reset values (async):
  - rf_write_enabled=0, rf_write_addr=0, rf_write_data=0.
  - init_done=0, init addr counter=0, rr_last=B (so A wins the first tie).
  - state=INIT if INIT_ON_RESET else RUN.
- Reset asserted mid-INIT aborts the walk; INIT restarts from addr 0 after release.
- States: INIT, RUN.
- INIT:
  - a_ready=b_ready=0; init_busy=1.
  - Each posedge loads outputs with {1, cnt, INIT_VALUE}, then cnt++.
  - The edge that loads cnt=31 moves state to RUN, pulses init_done for one cycle, and clears cnt to 0.
  - Result: exactly 32 consecutive write strobes, addr 0..31 ascending. Register 0 is written too; ZERO_REG_PROTECT does not apply.
  - init_start is ignored during INIT.
- RUN:
  - init_busy=0.
  - init_start=1 wins over any request: no ready that cycle, next state INIT.
  - Otherwise, grant logic (ready is combinational from valids, state and rr_last):
    - Only A valid -> a_ready=1.
    - Only B valid -> b_ready=1.
    - Both valid -> grant the requester that is not rr_last.
    - At most one ready per cycle.
  - Transfer = valid & ready. On transfer:
    - Next posedge loads rf_write_addr/rf_write_data with the granted addr/data.
    - rf_write_enabled=1, except 0 when ZERO_REG_PROTECT=1 and addr==0.
    - rr_last updates to the granted requester (including address-0 transfers).
  - No transfer -> rf_write_enabled=0 next cycle; addr/data hold their last values.
- Latency: transfer at cycle N -> rf strobe during cycle N+1 -> rf_32 captures at the end of N+1.
- Throughput: one write per cycle.
- Requesters must hold valid/addr/data stable until ready; valid may not depend on ready.
- A losing requester is never starved: it wins the next cycle in which it is still valid.

Optional Feature:
- Macro: RF_SCHED_STATS_EN.
- Defined:
  - Adds output conflict_count [15:0].
  - Increments by 1 each RUN cycle with a_valid&b_valid&!init_start; saturates at 16'hFFFF.
  - Reset to 0 by reset; cleared to 0 by an accepted init_start.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, INIT_ON_RESET=1, no requests -> 32 strobes addr 0..31 with data 0, init_done pulse on the cycle after the addr-31 strobe edge, then a_ready rises for a held a_valid; rf_32 reads 0 on all registers (no X).
- RUN, a_valid=1, a_addr=5, a_data=32'hDEADBEEF -> a_ready same cycle; next cycle rf_write_enabled=1, addr=5, data=DEADBEEF; rf_32 reg[5]=DEADBEEF.
- RUN, both valid and held for 4 cycles (A: addr 2/11111111, B: addr 3/22222222), rr_last=B -> grants A,B,A,B; strobes alternate reg2/reg3; with RF_SCHED_STATS_EN, conflict_count=4.
- ZERO_REG_PROTECT=1, a_addr=0, a_data=32'hFFFFFFFF -> a_ready=1, rf_write_enabled stays 0, reg[0] unchanged; the next tie goes to B.
- init_start in the same cycle as a_valid (addr 7) -> a_ready=0, INIT re-runs all 32 writes, then A is granted and reg[7] receives its data afterwards.
- Reset asserted when cnt=10 during INIT -> outputs clear asynchronously; after release the walk restarts at addr 0 and still produces 32 strobes.
